// File: rtl/mul_pkg.sv
// Shared constants and state type for the digit-serial 256x256 signed multiplier.
package mul_pkg;

  localparam int A_W       = 256;
  localparam int B_W       = 256;
  localparam int P_W       = A_W + B_W;
  localparam int DIG_W     = 63;
  localparam int N_DIG     = 5;
  localparam int BOOTH_B_W = 64;
  localparam int BOOTH_P_W = 320;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/booth_top.sv
// Combinational radix-4 Booth multiplier: signed i_a times signed i_b, exact signed o_p.
module booth_top #(
  parameter int A_W = 256,
  parameter int B_W = 64,
  parameter int P_W = 320
) (
  input  logic [A_W-1:0] i_a,
  input  logic [B_W-1:0] i_b,
  output logic [P_W-1:0] o_p
);

  logic [P_W-1:0] w_aExt;
  logic [P_W-1:0] w_aExt2;
  logic [B_W:0]   w_bExt;

  assign w_aExt  = {{(P_W-A_W){i_a[A_W-1]}}, i_a};
  assign w_aExt2 = w_aExt << 1;
  assign w_bExt  = {i_b, 1'b0};

  // Each overlapping 3-bit group of b recodes to a digit in {-2,-1,0,+1,+2}.
  always_comb begin
    logic [P_W-1:0] pp;
    o_p = '0;
    for (int i = 0; i < B_W/2; i++) begin
      pp = '0;
      case (w_bExt[2*i +: 3])
        3'b001, 3'b010: pp = w_aExt;
        3'b011:         pp = w_aExt2;
        3'b100:         pp = -w_aExt2;
        3'b101, 3'b110: pp = -w_aExt;
        default:        pp = '0;
      endcase
      o_p = o_p + (pp << (2*i));
    end
  end

endmodule

// File: rtl/mul256_seq.sv
// Signed 256x256 multiplier that reuses one 256x64 Booth core over five multiplier digits.
module mul256_seq #(
  parameter int A_W = mul_pkg::A_W,
  parameter int B_W = mul_pkg::B_W,
  parameter int P_W = A_W + B_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] in_a,
  input  logic [B_W-1:0] in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P_W-1:0] out_p,
  output logic           busy
);

  import mul_pkg::*;

  state_t               r_state;
  logic [A_W-1:0]       r_a;
  logic [B_W-1:0]       r_b;
  logic [P_W-1:0]       r_acc;
  logic [2:0]           r_cnt;

  logic [BOOTH_B_W-1:0] w_digit;
  logic [BOOTH_P_W-1:0] w_prod;
  logic [P_W-1:0]       w_prodExt;
  logic [8:0]           w_shamt;
  logic [P_W-1:0]       w_addend;

  // Low digits are unsigned 63-bit slices; only the top 4 bits carry the sign.
  always_comb begin
    w_digit = '0;
    case (r_cnt)
      3'd0:    w_digit = {1'b0, r_b[0*DIG_W +: DIG_W]};
      3'd1:    w_digit = {1'b0, r_b[1*DIG_W +: DIG_W]};
      3'd2:    w_digit = {1'b0, r_b[2*DIG_W +: DIG_W]};
      3'd3:    w_digit = {1'b0, r_b[3*DIG_W +: DIG_W]};
      3'd4:    w_digit = {{(BOOTH_B_W-4){r_b[B_W-1]}}, r_b[B_W-1 -: 4]};
      default: w_digit = '0;
    endcase
  end

  booth_top #(
    .A_W(A_W),
    .B_W(BOOTH_B_W),
    .P_W(BOOTH_P_W)
  ) u_booth (
    .i_a(r_a),
    .i_b(w_digit),
    .o_p(w_prod)
  );

  assign w_prodExt = {{(P_W-BOOTH_P_W){w_prod[BOOTH_P_W-1]}}, w_prod};
  assign w_shamt   = 9'(r_cnt) * 9'(DIG_W);
  assign w_addend  = w_prodExt << w_shamt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_acc <= r_acc + w_addend;
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'(N_DIG-1)) r_state <= DONE;
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_p     = r_acc;

endmodule

// File: tb/tb_mul256_seq.sv
// Directed vectors, handshake corner cases and a randomized scoreboard run for mul256_seq.
module tb_mul256_seq;

  localparam int N_RAND = 1000;

  typedef struct {
    logic [255:0] a;
    logic [255:0] b;
    logic [511:0] p;
    string        name;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_a;
  logic [255:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_p;
  logic         busy;

  int tests;
  int fails;

  mul256_seq dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_p(out_p),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] refMul(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] ea;
    logic [511:0] eb;
    ea = {{256{a[255]}}, a};
    eb = {{256{b[255]}}, b};
    return ea * eb;
  endfunction

  function automatic logic [255:0] randWide();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one operand pair from IDLE, measure latency, check the product, then drain it.
  task automatic applyStimulus(input logic [255:0] a, input logic [255:0] b,
                               input logic [511:0] exp, input string name);
    int lat;
    bit seen;
    lat  = 0;
    seen = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat  = k;
        seen = 1;
      end
    end
    checkOutput({name, " latency"}, 512'(lat), 512'd5);
    checkOutput({name, " product"}, out_p, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({name, " in_ready after drain"}, 512'(in_ready), 512'd1);
  endtask

  initial begin
    vec_t vecs[10];
    logic [511:0] expQ[$];
    logic [511:0] stallExp;
    int sent;
    int got;
    int cycles;
    bit accepted;
    bit sawValid;

    clk = 1'b0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    tests = 0;
    fails = 0;

    vecs[0] = '{256'd3, 256'd5, 512'd15, "3x5"};
    vecs[1] = '{{256{1'b1}}, {256{1'b1}}, 512'd1, "m1xm1"};
    vecs[2] = '{{1'b1, 255'd0}, {1'b1, 255'd0}, 512'd1 << 510, "minxmin"};
    vecs[3] = '{256'd1, 256'd1 << 63, 512'd1 << 63, "1x2^63"};
    vecs[4] = '{256'd0, {256{1'b1}}, 512'd0, "0xm1"};
    vecs[5] = '{{256{1'b1}}, 256'd5, 512'd0 - 512'd5, "m1x5"};
    vecs[6] = '{256'd1, 256'd1 << 126, 512'd1 << 126, "1x2^126"};
    vecs[7] = '{256'd2, {1'b1, 255'd0}, ~((512'd1 << 256) - 512'd1), "2xmin"};
    vecs[8] = '{{1'b0, {255{1'b1}}}, 256'd2, (512'd1 << 256) - 512'd2, "maxx2"};
    vecs[9] = '{256'd0 - 256'd3, 256'd1 << 252, 512'd0 - (512'd3 << 252), "m3x2^252"};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset in_ready", 512'(in_ready), 512'd1);
    checkOutput("reset out_valid", 512'(out_valid), 512'd0);
    checkOutput("reset busy", 512'(busy), 512'd0);
    checkOutput("reset out_p", out_p, 512'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].name);
    end

    // Hold the result in DONE while presenting operands that must be ignored.
    stallExp = 512'd56088;
    in_a = 256'd123;
    in_b = 256'd456;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_a = 256'd9;
    in_b = 256'd9;
    for (int k = 0; k < 20 && !out_valid; k++) begin
      @(posedge clk); #1;
    end
    checkOutput("stall reached DONE", 512'(out_valid), 512'd1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      checkOutput("stall out_valid", 512'(out_valid), 512'd1);
      checkOutput("stall in_ready", 512'(in_ready), 512'd0);
      checkOutput("stall out_p", out_p, stallExp);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("stall release in_ready", 512'(in_ready), 512'd1);
    checkOutput("stall release out_valid", 512'(out_valid), 512'd0);

    // Reset during the third CALC cycle must abandon the operation silently.
    in_a = 256'd11;
    in_b = 256'd13;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midreset in_ready", 512'(in_ready), 512'd1);
    checkOutput("midreset out_valid", 512'(out_valid), 512'd0);
    checkOutput("midreset busy", 512'(busy), 512'd0);
    sawValid = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (out_valid) sawValid = 1;
    end
    checkOutput("midreset no out_valid pulse", 512'(sawValid), 512'd0);
    applyStimulus(256'd7, 256'd0 - 256'd9, 512'd0 - 512'd63, "7xm9");

    // Randomized traffic with a scoreboard; handshakes are evaluated mid-cycle.
    sent = 0;
    got = 0;
    cycles = 0;
    in_valid = 1'b0;
    while (got < N_RAND && cycles < 40000) begin
      if (!in_valid && sent < N_RAND && $urandom_range(0, 3) != 0) begin
        in_a = randWide();
        in_b = randWide();
        in_valid = 1'b1;
      end
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      accepted = 0;
      if (in_valid && in_ready) begin
        expQ.push_back(refMul(in_a, in_b));
        sent++;
        accepted = 1;
      end
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("random unexpected product", 512'd1, 512'd0);
        end else begin
          checkOutput("random product", out_p, expQ.pop_front());
        end
        got++;
      end
      @(posedge clk); #1;
      if (accepted) in_valid = 1'b0;
      cycles++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checkOutput("random products received", 512'(got), 512'(N_RAND));
    checkOutput("random scoreboard empty", 512'(expQ.size()), 512'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
